pc_sequencer: RTL and testbench

Multi-cycle control sequencer for the picoMIPS core. It issues the increment and relative-branch commands to the program counter, the register-file write enable, and handshakes for the IN/OUT instructions. It sits between the instruction decoder and the PC/register file, and advances exactly one instruction per FETCH/EXEC pair. The core stalls only on I/O waits or HALT.

---
 rtl/pc_sequencer_if.sv | 32 +++
 rtl/pc_sequencer.sv | 66 ++++++
 tb/tb_pc_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decoder/handshake/PC-command bundle; carries step when PCSEQ_STEP_EN is defined
interface pc_sequencer_if #(parameter int Psize = 6);
  logic [2:0] opcode;
  logic [Psize-1:0] offset;
  logic zflag;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ack;
  logic PCincr;
  logic PCrelbranch;
  logic [Psize-1:0] Branchaddr;
  logic regwe;
  logic halted;
`ifdef PCSEQ_STEP_EN
  logic step;
`endif
  modport master(
`ifdef PCSEQ_STEP_EN
    input step,
`endif
    input opcode, offset, zflag, in_valid, out_ack,
    output in_ready, out_valid, PCincr, PCrelbranch, Branchaddr, regwe, halted
  );
  modport slave(
`ifdef PCSEQ_STEP_EN
    output step,
`endif
    output opcode, offset, zflag, in_valid, out_ack,
    input in_ready, out_valid, PCincr, PCrelbranch, Branchaddr, regwe, halted
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: picoMIPS FETCH/EXEC control sequencer with IN/OUT handshakes; PCSEQ_STEP_EN adds single-step
module pc_sequencer #(parameter int Psize = 6) (
  input logic clk,
  input logic reset,
  pc_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, FETCH, EXEC, WAIT_IN, WAIT_OUT, HALT
`ifdef PCSEQ_STEP_EN
    , STEP
`endif
  } state_t;
`ifdef PCSEQ_STEP_EN
  localparam state_t NEXT = STEP;
`else
  localparam state_t NEXT = FETCH;
`endif
  state_t state_q, state_d;
  logic in_ready, out_valid, pc_incr, pc_rel, regwe, halted, take;
  // state register
  always_ff @(posedge clk) state_q <= reset ? IDLE : state_d;
  // next state and per-state command decode
  always_comb begin
    state_d = state_q;
    in_ready = 1'b0;
    out_valid = 1'b0;
    pc_incr = 1'b0;
    pc_rel = 1'b0;
    regwe = 1'b0;
    halted = 1'b0;
    take = (bus.opcode == 3'd3 && bus.zflag) || (bus.opcode == 3'd4 && !bus.zflag);
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: state_d = EXEC;
      EXEC: begin
        pc_rel = take;
        pc_incr = bus.opcode <= 3'd4 && !take;
        regwe = bus.opcode == 3'd1 || bus.opcode == 3'd2;
        state_d = bus.opcode == 3'd5 ? WAIT_IN : bus.opcode == 3'd6 ? WAIT_OUT : bus.opcode == 3'd7 ? HALT : NEXT;
      end
      WAIT_IN: begin
        in_ready = 1'b1;
        regwe = bus.in_valid;
        pc_incr = bus.in_valid;
        state_d = bus.in_valid ? NEXT : WAIT_IN;
      end
      WAIT_OUT: begin
        out_valid = 1'b1;
        pc_incr = bus.out_ack;
        state_d = bus.out_ack ? NEXT : WAIT_OUT;
      end
      HALT: halted = 1'b1;
`ifdef PCSEQ_STEP_EN
      STEP: state_d = bus.step ? FETCH : STEP;
`endif
      default: state_d = IDLE;
    endcase
  end
  assign bus.in_ready = !reset && in_ready;
  assign bus.out_valid = !reset && out_valid;
  assign bus.PCincr = !reset && pc_incr;
  assign bus.PCrelbranch = !reset && pc_rel;
  assign bus.Branchaddr = (!reset && pc_rel) ? bus.offset : {Psize{1'b0}};
  assign bus.regwe = !reset && regwe;
  assign bus.halted = !reset && halted;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized instruction-level check of pc_sequencer against a per-instruction reference
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic reset;
  logic [5:0] pc, pc_exp;
  logic [11:0] outs;
  int n_chk = 0, n_fail = 0;
  pc_sequencer_if #(.Psize(6)) bus();
  pc_sequencer #(.Psize(6)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign outs = {bus.in_ready, bus.out_valid, bus.PCincr, bus.PCrelbranch, bus.Branchaddr, bus.regwe, bus.halted};
  // program counter driven by the sequencer's commands, as in the core
  always_ff @(posedge clk)
    pc <= reset ? 6'd0 : bus.PCincr ? pc + 6'd1 : bus.PCrelbranch ? pc + bus.Branchaddr + 6'd1 : pc;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [11:0] mk(input logic ir, ov, inc, rel, input logic [5:0] ba, input logic we, h);
    return {ir, ov, inc, rel, ba, we, h};
  endfunction
  task automatic tick(input string tag, input logic [11:0] exp);
    #1 check(tag, {20'd0, outs}, {20'd0, exp});
    @(negedge clk);
  endtask
  task automatic noise();
    bus.in_valid = 1'($urandom);
    bus.out_ack = 1'($urandom);
  endtask
  // one instruction from FETCH onward; w = wait cycles before the handshake (or halt cycles)
  task automatic run_instr(input logic [2:0] op, input logic [5:0] off, input logic z, input int w);
    logic take;
    bus.opcode = op;
    bus.offset = off;
    bus.zflag = z;
    noise();
    tick("fetch", '0);
    noise();
    take = (op == 3'd3 && z) || (op == 3'd4 && !z);
    tick("exec", mk(0, 0, op <= 3'd4 && !take, take, take ? off : 6'd0, op == 3'd1 || op == 3'd2, 0));
    if (op <= 3'd4) pc_exp = take ? pc_exp + off + 6'd1 : pc_exp + 6'd1;
    if (op == 3'd5) begin
      bus.in_valid = 1'b0;
      repeat (w) tick("in_hold", mk(1, 0, 0, 0, 0, 0, 0));
      bus.in_valid = 1'b1;
      tick("in_done", mk(1, 0, 1, 0, 0, 1, 0));
      pc_exp = pc_exp + 6'd1;
    end
    if (op == 3'd6) begin
      bus.out_ack = 1'b0;
      repeat (w) tick("out_hold", mk(0, 1, 0, 0, 0, 0, 0));
      bus.out_ack = 1'b1;
      tick("out_done", mk(0, 1, 1, 0, 0, 0, 0));
      pc_exp = pc_exp + 6'd1;
    end
    if (op == 3'd7) repeat (w) tick("halt", mk(0, 0, 0, 0, 0, 0, 1));
    check("pc", {26'd0, pc}, {26'd0, pc_exp});
`ifdef PCSEQ_STEP_EN
    if (op != 3'd7) begin
      if (!bus.step) repeat (3) tick("park", '0);
      bus.step = 1'b1;
      tick("step", '0);
    end
`endif
  endtask
  task automatic do_reset();
    reset = 1'b1;
    noise();
    tick("reset", '0);
    reset = 1'b0;
    tick("idle", '0);
    pc_exp = 6'd0;
  endtask
  initial begin
    reset = 1'b1;
    bus.opcode = 3'd0;
    bus.offset = 6'd0;
    bus.zflag = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ack = 1'b0;
`ifdef PCSEQ_STEP_EN
    bus.step = 1'b1;
`endif
    @(negedge clk);
    do_reset();
    repeat (3) run_instr(3'd1, 6'd0, 1'b0, 0);
    run_instr(3'd0, 6'd0, 1'b0, 0);
    run_instr(3'd2, 6'd0, 1'b0, 0);
    run_instr(3'd3, 6'h3E, 1'b1, 0);
    run_instr(3'd0, 6'd0, 1'b0, 0);
    run_instr(3'd3, 6'h3E, 1'b0, 0);
    run_instr(3'd4, 6'h05, 1'b0, 0);
    run_instr(3'd5, 6'd0, 1'b0, 4);
    run_instr(3'd6, 6'd0, 1'b0, 0);
    run_instr(3'd6, 6'd0, 1'b0, 2);
`ifdef PCSEQ_STEP_EN
    bus.step = 1'b0;
    run_instr(3'd0, 6'd0, 1'b0, 0);
    bus.step = 1'b0;
    run_instr(3'd1, 6'd0, 1'b0, 0);
`endif
    run_instr(3'd7, 6'd0, 1'b0, 10);
    do_reset();
    bus.opcode = 3'd5;
    tick("fetch", '0);
    tick("exec", '0);
    bus.in_valid = 1'b1;
    reset = 1'b1;
    tick("rst_win", '0);
    reset = 1'b0;
    tick("idle", '0);
    check("pc_rst", {26'd0, pc}, 32'd0);
    pc_exp = 6'd0;
    for (int i = 0; i < 60; i++)
      run_instr(3'($urandom_range(0, 6)), 6'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    run_instr(3'd7, 6'd0, 1'b0, 3);
    do_reset();
    run_instr(3'd1, 6'd0, 1'b0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
